// File: rtl/qspi_target_shifter.sv
// qspi_target_shifter
// Oversampling Quad-SPI target. Samples SCLK, CS_n and the data pads with clk_i,
// decodes instruction / address / data phases and either pushes received write
// bytes out or serves read bytes from a show-ahead source.
//
// Optional feature macro: QSPI_TGT_FRAME_ERR_EN (truncated-frame detection on
// frame_err_o; when undefined frame_err_o is tied low).
//
// Ports:
//   clk_i, rst_i            system clock (>= 8x SCLK), synchronous active-high reset
//   spi_clk_i, spi_cs_n_i   external SCLK (mode 0) and chip select from the pads
//   spi_d_i / spi_d_o       data lanes from / to the pads
//   spi_d_oe                per-lane output enable (1 = drive)
//   cfg_*_i                 static frame layout (lane modes, address size, direction)
//   cmd_valid_o/_instr_o/_addr_o  header-complete pulse with captured fields
//   wr_dat_o, wr_dat_valid_o      received data byte and its one-cycle strobe
//   rd_dat_i, rd_dat_rdreq_o      show-ahead read byte and its consume pulse
//   busy_o                  frame in progress
//   frame_err_o             one-cycle pulse on a truncated frame

module qspi_target_shifter #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        spi_clk_i,
    input  logic        spi_cs_n_i,
    input  logic [3:0]  spi_d_i,
    output logic [3:0]  spi_d_o,
    output logic [3:0]  spi_d_oe,
    input  logic [1:0]  cfg_imode_i,
    input  logic [1:0]  cfg_admode_i,
    input  logic [1:0]  cfg_dmode_i,
    input  logic [1:0]  cfg_adsize_i,
    input  logic [1:0]  cfg_fmode_i,
    output logic        cmd_valid_o,
    output logic [7:0]  cmd_instr_o,
    output logic [31:0] cmd_addr_o,
    output logic [7:0]  wr_dat_o,
    output logic        wr_dat_valid_o,
    input  logic [7:0]  rd_dat_i,
    output logic        rd_dat_rdreq_o,
    output logic        busy_o,
    output logic        frame_err_o
);

    localparam int unsigned CNT_W  = 6;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned LANE_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INSTR,
        ST_ADDR,
        ST_WR_DA,
        ST_RD_DA,
        ST_SKIP
    } state_e;

    // ------------------------------------------------------------------
    // Pad synchronizers and edge strobes
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0]             sclk_sync_q;
    logic [SYNC_STAGES-1:0]             cs_sync_q;
    logic [SYNC_STAGES-1:0][LANE_W-1:0] d_sync_q;
    logic                               sclk_prev_q;
    logic                               cs_prev_q;

    // CS_n history resets to "low" so a frame already in progress when reset
    // releases never produces a falling edge; a real high must be seen first.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '0;
            d_sync_q    <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk_i};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n_i};
            d_sync_q    <= {d_sync_q[SYNC_STAGES-2:0], spi_d_i};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
            cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
        end
    end

    logic              sclk_s;
    logic              cs_s;
    logic [LANE_W-1:0] d_s;
    logic              sclk_rise;
    logic              sclk_fall;
    logic              cs_fall;
    logic              cs_rise;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign d_s       = d_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q & ~cs_s;
    assign sclk_fall = ~sclk_s & sclk_prev_q & ~cs_s;
    assign cs_fall   = ~cs_s & cs_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   sh_q, sh_d;
    logic [BYTE_W-1:0]   instr_q, instr_d;
    logic [BYTE_W-1:0]   rsh_q, rsh_d;
    logic [LANE_W-1:0]   d_out_q, d_out_d;
    logic [LANE_W-1:0]   oe_q, oe_d;
    logic                cmd_valid_q, cmd_valid_d;
    logic [BYTE_W-1:0]   cmd_instr_q, cmd_instr_d;
    logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
    logic [BYTE_W-1:0]   wr_dat_q, wr_dat_d;
    logic                wr_valid_q, wr_valid_d;
    logic                rdreq_q, rdreq_d;
    logic                busy_q, busy_d;

    // ------------------------------------------------------------------
    // Phase helpers: active lane mode, bits per edge, sampled / driven lanes
    // ------------------------------------------------------------------
    logic [1:0]        phase_mode;
    logic [CNT_W-1:0]  nbits;
    logic [LANE_W-1:0] lanes_in;
    logic [ADDR_W-1:0] sh_shift;
    logic [CNT_W-1:0]  cnt_inc;
    logic [CNT_W-1:0]  hdr_bits;
    logic [BYTE_W-1:0] rd_src;
    logic [LANE_W-1:0] rd_lanes;
    logic [LANE_W-1:0] oe_mask;
    state_e            data_st;

    always_comb begin
        phase_mode = cfg_dmode_i;
        case (state_q)
            ST_INSTR: phase_mode = cfg_imode_i;
            ST_ADDR:  phase_mode = cfg_admode_i;
            default:  ;
        endcase

        nbits    = '0;
        lanes_in = '0;
        rd_lanes = 4'hf;
        oe_mask  = '0;
        rd_src   = (cnt_q == '0) ? rd_dat_i : rsh_q;
        case (phase_mode)
            2'b01: begin
                nbits    = CNT_W'(1);
                lanes_in = {3'b000, d_s[0]};
                rd_lanes = {2'b11, rd_src[7], 1'b1};
                oe_mask  = 4'b0010;
            end
            2'b10: begin
                nbits    = CNT_W'(2);
                lanes_in = {2'b00, d_s[1:0]};
                rd_lanes = {2'b11, rd_src[7:6]};
                oe_mask  = 4'b0011;
            end
            2'b11: begin
                nbits    = CNT_W'(4);
                lanes_in = d_s;
                rd_lanes = rd_src[7:4];
                oe_mask  = 4'b1111;
            end
            default: ;
        endcase

        sh_shift = (sh_q << nbits) | ADDR_W'(lanes_in);
        cnt_inc  = cnt_q + nbits;
        hdr_bits = CNT_W'({cfg_adsize_i, 3'b000}) + CNT_W'(8);

        if ((cfg_dmode_i == 2'b00) || cfg_fmode_i[1]) begin
            data_st = ST_SKIP;
        end else if (cfg_fmode_i[0]) begin
            data_st = ST_RD_DA;
        end else begin
            data_st = ST_WR_DA;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state; CS_n rising always wins over a same-cycle SCLK edge
    always_comb begin
        state_d = state_q;
        if (cs_rise) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cs_fall) begin
                        if (cfg_imode_i != 2'b00) begin
                            state_d = ST_INSTR;
                        end else if (cfg_admode_i != 2'b00) begin
                            state_d = ST_ADDR;
                        end else begin
                            state_d = data_st;
                        end
                    end
                end
                ST_INSTR: begin
                    if (sclk_rise && (cnt_inc == CNT_W'(8))) begin
                        state_d = (cfg_admode_i != 2'b00) ? ST_ADDR : data_st;
                    end
                end
                ST_ADDR: begin
                    if (sclk_rise && (cnt_inc == hdr_bits)) begin
                        state_d = data_st;
                    end
                end
                default: ;
            endcase
        end
    end

    // FSM: datapath and output next values
    always_comb begin
        cnt_d       = cnt_q;
        sh_d        = sh_q;
        instr_d     = instr_q;
        rsh_d       = rsh_q;
        d_out_d     = d_out_q;
        oe_d        = oe_q;
        cmd_valid_d = 1'b0;
        cmd_instr_d = cmd_instr_q;
        cmd_addr_d  = cmd_addr_q;
        wr_dat_d    = wr_dat_q;
        wr_valid_d  = 1'b0;
        rdreq_d     = 1'b0;
        busy_d      = busy_q;

        if (cs_rise) begin
            cnt_d   = '0;
            sh_d    = '0;
            oe_d    = '0;
            d_out_d = 4'hf;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cs_fall) begin
                        cnt_d   = '0;
                        sh_d    = '0;
                        instr_d = '0;
                        rsh_d   = '0;
                        oe_d    = '0;
                        d_out_d = 4'hf;
                        busy_d  = 1'b1;
                    end
                end
                ST_INSTR: begin
                    if (sclk_rise) begin
                        if (cnt_inc == CNT_W'(8)) begin
                            cnt_d   = '0;
                            sh_d    = '0;
                            instr_d = sh_shift[7:0];
                            // Instruction-only header completes here.
                            if (cfg_admode_i == 2'b00) begin
                                cmd_valid_d = 1'b1;
                                cmd_instr_d = sh_shift[7:0];
                                cmd_addr_d  = '0;
                            end
                        end else begin
                            cnt_d = cnt_inc;
                            sh_d  = sh_shift;
                        end
                    end
                end
                ST_ADDR: begin
                    if (sclk_rise) begin
                        if (cnt_inc == hdr_bits) begin
                            cnt_d       = '0;
                            sh_d        = '0;
                            cmd_valid_d = 1'b1;
                            cmd_instr_d = instr_q;
                            cmd_addr_d  = sh_shift;
                        end else begin
                            cnt_d = cnt_inc;
                            sh_d  = sh_shift;
                        end
                    end
                end
                ST_WR_DA: begin
                    if (sclk_rise) begin
                        if (cnt_inc == CNT_W'(8)) begin
                            cnt_d      = '0;
                            sh_d       = '0;
                            wr_dat_d   = sh_shift[7:0];
                            wr_valid_d = 1'b1;
                        end else begin
                            cnt_d = cnt_inc;
                            sh_d  = sh_shift;
                        end
                    end
                end
                ST_RD_DA: begin
                    // A fall with an empty bit count starts a new byte from the source.
                    if (sclk_fall) begin
                        rdreq_d = (cnt_q == '0);
                        rsh_d   = rd_src << nbits;
                        cnt_d   = (cnt_inc == CNT_W'(8)) ? '0 : cnt_inc;
                        oe_d    = oe_mask;
                        d_out_d = rd_lanes;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q       <= '0;
            sh_q        <= '0;
            instr_q     <= '0;
            rsh_q       <= '0;
            d_out_q     <= 4'hf;
            oe_q        <= '0;
            cmd_valid_q <= 1'b0;
            cmd_instr_q <= '0;
            cmd_addr_q  <= '0;
            wr_dat_q    <= '0;
            wr_valid_q  <= 1'b0;
            rdreq_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            instr_q     <= instr_d;
            rsh_q       <= rsh_d;
            d_out_q     <= d_out_d;
            oe_q        <= oe_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_instr_q <= cmd_instr_d;
            cmd_addr_q  <= cmd_addr_d;
            wr_dat_q    <= wr_dat_d;
            wr_valid_q  <= wr_valid_d;
            rdreq_q     <= rdreq_d;
            busy_q      <= busy_d;
        end
    end

`ifdef QSPI_TGT_FRAME_ERR_EN
    logic frame_err_q, frame_err_d;

    // Truncated frame: header cut short, or data phase with a partial byte.
    always_comb begin
        frame_err_d = 1'b0;
        if (cs_rise) begin
            case (state_q)
                ST_INSTR, ST_ADDR:  frame_err_d = 1'b1;
                ST_WR_DA, ST_RD_DA: frame_err_d = (cnt_q != '0);
                default:            frame_err_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= frame_err_d;
        end
    end

    assign frame_err_o = frame_err_q;
`else
    assign frame_err_o = 1'b0;
`endif

    assign spi_d_o        = d_out_q;
    assign spi_d_oe       = oe_q;
    assign cmd_valid_o    = cmd_valid_q;
    assign cmd_instr_o    = cmd_instr_q;
    assign cmd_addr_o     = cmd_addr_q;
    assign wr_dat_o       = wr_dat_q;
    assign wr_dat_valid_o = wr_valid_q;
    assign rd_dat_rdreq_o = rdreq_q;
    assign busy_o         = busy_q;

endmodule

// File: tb/tb_qspi_target_shifter.sv
// Self-checking bench for qspi_target_shifter: a QSPI host model drives frames,
// a negedge monitor collects DUT pulses, and each test compares the collected
// results against the frame it intended to send.

module tb_qspi_target_shifter;

    localparam int H = 6; // SCLK half period in clk cycles (SCLK = clk/12)

    logic        clk = 1'b0;
    logic        rst;
    logic        spi_clk;
    logic        spi_cs_n;
    logic [3:0]  spi_d;
    logic [3:0]  spi_d_o;
    logic [3:0]  spi_d_oe;
    logic [1:0]  imode, admode, dmode, adsize, fmode;
    logic        cmd_valid;
    logic [7:0]  cmd_instr;
    logic [31:0] cmd_addr;
    logic [7:0]  wr_dat;
    logic        wr_valid;
    logic [7:0]  rd_dat;
    logic        rdreq;
    logic        busy;
    logic        frame_err;

    always #5 clk = ~clk;

    qspi_target_shifter #(.SYNC_STAGES(2)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .spi_clk_i      (spi_clk),
        .spi_cs_n_i     (spi_cs_n),
        .spi_d_i        (spi_d),
        .spi_d_o        (spi_d_o),
        .spi_d_oe       (spi_d_oe),
        .cfg_imode_i    (imode),
        .cfg_admode_i   (admode),
        .cfg_dmode_i    (dmode),
        .cfg_adsize_i   (adsize),
        .cfg_fmode_i    (fmode),
        .cmd_valid_o    (cmd_valid),
        .cmd_instr_o    (cmd_instr),
        .cmd_addr_o     (cmd_addr),
        .wr_dat_o       (wr_dat),
        .wr_dat_valid_o (wr_valid),
        .rd_dat_i       (rd_dat),
        .rd_dat_rdreq_o (rdreq),
        .busy_o         (busy),
        .frame_err_o    (frame_err)
    );

    int checks = 0;
    int failures = 0;

    // Monitor / host-model state
    int          cmd_cnt, rdreq_cnt, ferr_cnt, oe_bad, oe_err, rd_idx;
    logic [7:0]  cmd_instr_seen;
    logic [31:0] cmd_addr_seen;
    logic [7:0]  got_wr[$];
    logic [7:0]  got_rd[$];
    logic [7:0]  src[$];
    bit          in_data = 1'b0;

    always @(negedge clk) begin
        if (cmd_valid === 1'b1) begin
            cmd_cnt++;
            cmd_instr_seen = cmd_instr;
            cmd_addr_seen  = cmd_addr;
        end
        if (wr_valid === 1'b1) got_wr.push_back(wr_dat);
        if (rdreq === 1'b1) begin
            rdreq_cnt++;
            rd_idx++;
            rd_dat = (rd_idx < src.size()) ? src[rd_idx] : 8'h00;
        end
        if (frame_err === 1'b1) ferr_cnt++;
        if (!in_data && spi_d_oe !== 4'h0) oe_bad++;
    end

    function automatic int lane_w(input logic [1:0] m);
        return (m == 2'b01) ? 1 : (m == 2'b10) ? 2 : 4;
    endfunction

    function automatic bit q_equal(input logic [7:0] a[$], input logic [7:0] b[$]);
        if (a.size() != b.size()) return 1'b0;
        foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] pack_q(input logic [7:0] a[$]);
        logic [31:0] r = '0;
        foreach (a[i]) r = (r << 8) | 32'(a[i]);
        return r;
    endfunction

    task automatic clear_mon();
        cmd_cnt = 0; rdreq_cnt = 0; ferr_cnt = 0; oe_bad = 0; oe_err = 0;
        got_wr.delete(); got_rd.delete();
    endtask

    task automatic set_cfg(input logic [1:0] im, am, asz, dm, fm);
        imode = im; admode = am; adsize = asz; dmode = dm; fmode = fm;
    endtask

    task automatic load_src(input logic [7:0] a[$]);
        src = a; rd_idx = 0;
        rd_dat = (src.size() > 0) ? src[0] : 8'h00;
    endtask

    task automatic cs_low();
        @(negedge clk);
        spi_cs_n = 1'b0;
        repeat (H) @(negedge clk);
    endtask

    // Host drives lanes while SCLK is low, raises, then lowers SCLK (mode 0).
    task automatic send_bits(input logic [31:0] v, input int nbits, input logic [1:0] mode);
        int w;
        logic [3:0]  m;
        logic [31:0] chunk;
        w = lane_w(mode);
        m = 4'((1 << w) - 1);
        for (int i = nbits / w - 1; i >= 0; i--) begin
            chunk = (v >> (i * w)) & 32'(m);
            spi_d = (4'($urandom) & ~m) | chunk[3:0];
            repeat (H) @(negedge clk);
            spi_clk = 1'b1;
            repeat (H) @(negedge clk);
            spi_clk = 1'b0;
        end
    endtask

    // Host samples read lanes just before each rise; last rise leaves SCLK high.
    task automatic recv_bytes(input int n, input logic [1:0] mode);
        int w;
        logic [7:0] b;
        logic [3:0] m;
        w = lane_w(mode);
        m = (mode == 2'b01) ? 4'b0010 : (mode == 2'b10) ? 4'b0011 : 4'b1111;
        for (int k = 0; k < n; k++) begin
            b = '0;
            for (int g = 0; g < 8 / w; g++) begin
                repeat (H) @(negedge clk);
                case (mode)
                    2'b01:   b = {b[6:0], spi_d_o[1]};
                    2'b10:   b = {b[5:0], spi_d_o[1:0]};
                    default: b = {b[3:0], spi_d_o};
                endcase
                if (spi_d_oe !== m || (spi_d_o | m) !== 4'hf) oe_err++;
                spi_clk = 1'b1;
                repeat (H) @(negedge clk);
                if (!(k == n - 1 && g == 8 / w - 1)) spi_clk = 1'b0;
            end
            got_rd.push_back(b);
        end
    endtask

    task automatic end_frame();
        spi_cs_n = 1'b1;
        repeat (H) @(negedge clk);
        spi_clk = 1'b0;
        repeat (2 * H) @(negedge clk);
        in_data = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({spi_d_o, spi_d_oe} !== 8'hf0) begin
            failures++; $display("FAIL reset_pads got=%h want=f0", {spi_d_o, spi_d_oe});
        end
        checks++;
        if ({cmd_valid, wr_valid, rdreq, busy, frame_err} !== 5'b0 ||
            cmd_instr !== 8'h00 || cmd_addr !== 32'h0 || wr_dat !== 8'h00) begin
            failures++;
            $display("FAIL reset_outputs got=%b %h %h %h want=00000 00 00000000 00",
                     {cmd_valid, wr_valid, rdreq, busy, frame_err}, cmd_instr, cmd_addr, wr_dat);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        clear_mon();
    endtask

    task automatic test_single_write();
        logic [7:0] exp_wr[$] = '{8'hA5, 8'h3C};
        clear_mon();
        set_cfg(2'b01, 2'b01, 2'b10, 2'b01, 2'b00);
        cs_low();
        send_bits(32'h02, 8, 2'b01);
        send_bits(32'h123456, 24, 2'b01);
        send_bits(32'hA5, 8, 2'b01);
        send_bits(32'h3C, 8, 2'b01);
        end_frame();
        checks++;
        if (cmd_cnt != 1 || cmd_instr_seen !== 8'h02 || cmd_addr_seen !== 32'h00123456) begin
            failures++;
            $display("FAIL sw_header got=%0d/%h/%h want=1/02/00123456", cmd_cnt, cmd_instr_seen, cmd_addr_seen);
        end
        checks++;
        if (!q_equal(got_wr, exp_wr)) begin
            failures++; $display("FAIL sw_data got=%h (n=%0d) want=a53c", pack_q(got_wr), got_wr.size());
        end
        checks++;
        if (oe_bad != 0 || rdreq_cnt != 0) begin
            failures++; $display("FAIL sw_no_drive got oe_bad=%0d rdreq=%0d want=0/0", oe_bad, rdreq_cnt);
        end
    endtask

    task automatic test_quad_read();
        logic [7:0] s[$] = '{8'h11, 8'h22, 8'h33};
        clear_mon();
        load_src(s);
        set_cfg(2'b01, 2'b11, 2'b11, 2'b11, 2'b01);
        cs_low();
        send_bits(32'hEB, 8, 2'b01);
        send_bits(32'h89ABCDEF, 32, 2'b11);
        in_data = 1'b1;
        recv_bytes(3, 2'b11);
        end_frame();
        checks++;
        if (cmd_cnt != 1 || cmd_instr_seen !== 8'hEB || cmd_addr_seen !== 32'h89ABCDEF) begin
            failures++;
            $display("FAIL qr_header got=%0d/%h/%h want=1/eb/89abcdef", cmd_cnt, cmd_instr_seen, cmd_addr_seen);
        end
        checks++;
        if (!q_equal(got_rd, s)) begin
            failures++; $display("FAIL qr_data got=%h want=112233", pack_q(got_rd));
        end
        checks++;
        if (rdreq_cnt != 3) begin
            failures++; $display("FAIL qr_rdreq got=%0d want=3", rdreq_cnt);
        end
        checks++;
        if (oe_err != 0 || oe_bad != 0) begin
            failures++; $display("FAIL qr_oe got err=%0d bad=%0d want=0/0", oe_err, oe_bad);
        end
    endtask

    task automatic test_dual_noinstr();
        logic [7:0] exp_wr[$] = '{8'hC3};
        clear_mon();
        set_cfg(2'b00, 2'b10, 2'b00, 2'b10, 2'b00);
        cs_low();
        send_bits(32'h5A, 8, 2'b10);
        send_bits(32'hC3, 8, 2'b10);
        end_frame();
        checks++;
        if (cmd_cnt != 1 || cmd_instr_seen !== 8'h00 || cmd_addr_seen !== 32'h0000005A) begin
            failures++;
            $display("FAIL dual_header got=%0d/%h/%h want=1/00/0000005a", cmd_cnt, cmd_instr_seen, cmd_addr_seen);
        end
        checks++;
        if (!q_equal(got_wr, exp_wr)) begin
            failures++; $display("FAIL dual_data got=%h (n=%0d) want=c3", pack_q(got_wr), got_wr.size());
        end
    endtask

    task automatic test_instr_only(input logic [7:0] ins);
        clear_mon();
        set_cfg(2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
        cs_low();
        checks++;
        if (busy !== 1'b1) begin
            failures++; $display("FAIL io_busy_on got=%b want=1", busy);
        end
        send_bits(32'(ins), 8, 2'b01);
        send_bits(32'($urandom), 4, 2'b01);
        end_frame();
        checks++;
        if (cmd_cnt != 1 || cmd_instr_seen !== ins || cmd_addr_seen !== 32'h0) begin
            failures++;
            $display("FAIL io_header got=%0d/%h/%h want=1/%h/00000000", cmd_cnt, cmd_instr_seen, cmd_addr_seen, ins);
        end
        checks++;
        if (got_wr.size() != 0 || busy !== 1'b0) begin
            failures++; $display("FAIL io_tail got wr=%0d busy=%b want=0/0", got_wr.size(), busy);
        end
    endtask

    task automatic test_abort();
        int exp_ferr;
`ifdef QSPI_TGT_FRAME_ERR_EN
        exp_ferr = 1;
`else
        exp_ferr = 0;
`endif
        clear_mon();
        set_cfg(2'b01, 2'b01, 2'b10, 2'b01, 2'b00);
        cs_low();
        send_bits(32'h03, 8, 2'b01);
        send_bits(32'hABC, 12, 2'b01);
        end_frame();
        checks++;
        if (ferr_cnt != exp_ferr) begin
            failures++; $display("FAIL abort_ferr got=%0d want=%0d", ferr_cnt, exp_ferr);
        end
        checks++;
        if (cmd_cnt != 0) begin
            failures++; $display("FAIL abort_cmd got=%0d want=0", cmd_cnt);
        end
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] s[$] = '{8'h96, 8'h69};
        clear_mon();
        load_src(s);
        set_cfg(2'b01, 2'b11, 2'b11, 2'b11, 2'b01);
        cs_low();
        send_bits(32'hEB, 8, 2'b01);
        send_bits(32'h01020304, 32, 2'b11);
        in_data = 1'b1;
        recv_bytes(1, 2'b11);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (spi_d_oe !== 4'h0 || spi_d_o !== 4'hf || busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid got oe=%h d=%h busy=%b want=0/f/0", spi_d_oe, spi_d_o, busy);
        end
        rst = 1'b0;
        in_data = 1'b0;
        spi_clk = 1'b0;
        clear_mon();
        send_bits(32'hFFFF, 16, 2'b11);
        checks++;
        if (rdreq_cnt != 0 || oe_bad != 0 || busy !== 1'b0 || cmd_cnt != 0) begin
            failures++;
            $display("FAIL rst_ignore got rdreq=%0d oe_bad=%0d busy=%b cmd=%0d want=0/0/0/0",
                     rdreq_cnt, oe_bad, busy, cmd_cnt);
        end
        end_frame();
    endtask

    task automatic test_random();
        logic [1:0]  im, am, asz, dm, fm;
        logic [7:0]  ins;
        logic [31:0] ad, amask;
        int          nb;
        bit          is_wr, is_rd, hdr;
        logic [7:0]  bytes[$];
        logic [7:0]  exp_wr[$];
        for (int it = 0; it < 14; it++) begin
            im  = 2'($urandom_range(0, 3));
            am  = 2'($urandom_range(0, 3));
            asz = 2'($urandom_range(0, 3));
            dm  = 2'($urandom_range(0, 3));
            fm  = 2'($urandom_range(0, 3));
            if (fm == 2'b01 && dm != 2'b00 && im == 2'b00 && am == 2'b00) am = 2'b01;
            ins = 8'($urandom);
            ad  = $urandom;
            nb  = $urandom_range(1, 3);
            bytes.delete();
            for (int k = 0; k < nb; k++) bytes.push_back(8'($urandom));
            is_wr = (dm != 2'b00) && (fm == 2'b00);
            is_rd = (dm != 2'b00) && (fm == 2'b01);
            hdr   = (im != 2'b00) || (am != 2'b00);
            amask = (asz == 2'b11) ? 32'hFFFF_FFFF : ((32'd1 << (8 * (int'(asz) + 1))) - 32'd1);
            exp_wr.delete();
            if (is_wr) exp_wr = bytes;

            clear_mon();
            load_src(bytes);
            set_cfg(im, am, asz, dm, fm);
            cs_low();
            if (im != 2'b00) send_bits(32'(ins), 8, im);
            if (am != 2'b00) send_bits(ad, 8 * (int'(asz) + 1), am);
            if (is_wr) begin
                foreach (bytes[k]) send_bits(32'(bytes[k]), 8, dm);
            end else if (is_rd) begin
                in_data = 1'b1;
                recv_bytes(nb, dm);
            end else begin
                send_bits(32'($urandom), 4, 2'b01);
            end
            end_frame();

            checks++;
            if (cmd_cnt != (hdr ? 1 : 0)) begin
                failures++; $display("FAIL rnd%0d_cmdcnt got=%0d want=%0d", it, cmd_cnt, hdr ? 1 : 0);
            end
            if (hdr) begin
                checks++;
                if (cmd_instr_seen !== ((im != 2'b00) ? ins : 8'h00) ||
                    cmd_addr_seen !== ((am != 2'b00) ? (ad & amask) : 32'h0)) begin
                    failures++;
                    $display("FAIL rnd%0d_header got=%h/%h want=%h/%h", it, cmd_instr_seen, cmd_addr_seen,
                             (im != 2'b00) ? ins : 8'h00, (am != 2'b00) ? (ad & amask) : 32'h0);
                end
            end
            checks++;
            if (!q_equal(got_wr, exp_wr)) begin
                failures++;
                $display("FAIL rnd%0d_wr got=%h (n=%0d) want=%h (n=%0d)", it, pack_q(got_wr), got_wr.size(),
                         pack_q(exp_wr), exp_wr.size());
            end
            checks++;
            if (rdreq_cnt != (is_rd ? nb : 0) || (is_rd && !q_equal(got_rd, bytes))) begin
                failures++;
                $display("FAIL rnd%0d_rd got=%h rdreq=%0d want=%h rdreq=%0d", it, pack_q(got_rd), rdreq_cnt,
                         pack_q(bytes), is_rd ? nb : 0);
            end
            checks++;
            if (ferr_cnt != 0 || oe_bad != 0 || oe_err != 0) begin
                failures++;
                $display("FAIL rnd%0d_clean got ferr=%0d oe_bad=%0d oe_err=%0d want=0/0/0", it, ferr_cnt, oe_bad, oe_err);
            end
        end
    endtask

    initial begin
        rst = 1'b1; spi_clk = 1'b0; spi_cs_n = 1'b1; spi_d = 4'h0;
        rd_dat = 8'h00; rd_idx = 0;
        set_cfg(2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        clear_mon();
        test_reset();
        test_single_write();
        test_quad_read();
        test_dual_noinstr();
        test_instr_only(8'h06);
        test_abort();
        test_single_write();
        test_reset_mid_read();
        test_instr_only(8'h9F);
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/qspi_target_shifter.md
# qspi_target_shifter

Oversampling Quad-SPI target (responder) that decodes frames issued by the team's QSPI controller shifter: instruction, address, then write data (captured and pushed out) or read data (pulled from a show-ahead source and driven back). It sits behind the pad ring in flash-model / SPI-slave subsystems and samples the external SCLK, CS_n and data lines with the local system clock. Frame layout (lane widths, address size, direction) is static configuration matching the controller's settings.

## Interface
- SYNC_STAGES, 2, synchronizer depth on spi_clk_i, spi_cs_n_i and spi_d_i (minimum 2)
- clk_i  in  1  system clock; must be at least 8x the SCLK frequency
- rst_i  in  1  reset, synchronous, active-high
- spi_clk_i  in  1  external SCLK (mode 0: idle low)
- spi_cs_n_i  in  1  external chip select, active-low
- spi_d_i  in  4  data lines from pads
- spi_d_o  out  4  data lines to pads
- spi_d_oe  out  4  per-lane output enable, 1 = drive
- cfg_imode_i / cfg_admode_i / cfg_dmode_i  in  2 each  00 none, 01 single, 10 dual, 11 quad
- cfg_adsize_i  in  2  address bytes = cfg_adsize_i+1
- cfg_fmode_i  in  2  00 write (host to target), 01 read; 1x: data phase ignored
- cmd_valid_o  out  1  one-clk pulse: header (instruction+address) complete
- cmd_instr_o  out  8  captured instruction (0x00 if no instruction phase)
- cmd_addr_o  out  32  captured address, right-justified, zero-extended
- wr_dat_o  out  8  received data byte
- wr_dat_valid_o  out  1  one-clk pulse per complete received byte
- rd_dat_i  in  8  next read byte, valid whenever sampled (show-ahead)
- rd_dat_rdreq_o  out  1  one-clk pulse: rd_dat_i consumed
- busy_o  out  1  frame in progress
- frame_err_o  out  1  one-clk pulse on truncated frame (see Configuration)

## Operation
- Synchronize SCLK, CS_n, D through SYNC_STAGES flops; edge-detect stage produces sclk_rise / sclk_fall / cs_fall / cs_rise strobes, qualified by synchronized CS_n low.
- States: IDLE, INSTR, ADDR, WR_DA, RD_DA, SKIP.
- IDLE, cs_fall: go to INSTR if imode!=00, else ADDR if admode!=00, else WR_DA/RD_DA per fmode if dmode!=00, else SKIP. Clear counters and shift registers.
- Bits per sclk_rise: 1/2/4 for single/dual/quad. Single-line input on d[0]; dual on d[1:0]; quad on d[3:0]; MSB first, higher lane = higher bit.
- INSTR: 8 bits shifted on rises; then ADDR, data phase or SKIP as above.
- ADDR: (adsize+1)*8 bits; on completion pulse cmd_valid_o (also after INSTR if no address phase, then cmd_addr_o = 0).
- WR_DA: accumulate bits from dmode lanes; every 8 bits pulse wr_dat_valid_o with wr_dat_o. Unlimited bytes until CS_n high.
- RD_DA: output lane d[1] in single, d[1:0] dual, d[3:0] quad. On each sclk_fall that starts a byte, load rd_dat_i into shift register, pulse rd_dat_rdreq_o, drive MSB bits; subsequent falls shift. spi_d_oe asserted from first fall in RD_DA until CS_n high. Undriven lanes: spi_d_o = 1.
- fmode=1x or dmode=00 after header: SKIP, ignore SCLK until CS_n high.
- cs_rise in any state: IDLE, spi_d_oe = 0 same cycle as strobe, partial byte discarded.

## Timing
- Reset values: spi_d_o 4'hf, spi_d_oe 0, cmd_valid_o 0, cmd_instr_o 0, cmd_addr_o 0, wr_dat_o 0, wr_dat_valid_o 0, rd_dat_rdreq_o 0, busy_o 0, frame_err_o 0; state IDLE.
- Pin-edge to action latency: SYNC_STAGES+1 clk_i cycles; spi_d_o registered, valid SYNC_STAGES+2 cycles after SCLK pin fall.
- cmd_valid_o and wr_dat_valid_o assert the cycle after the final-bit sclk_rise strobe.
- busy_o = 1 from cycle after cs_fall strobe until cycle after cs_rise strobe.
- Reset with CS_n low: after reset the block stays IDLE until CS_n seen high, then low; no mid-frame resync.
- cs_rise and sclk_rise in same cycle: cs_rise wins, no bit captured.

## Configuration
- QSPI_TGT_FRAME_ERR_EN defined: frame_err_o pulses one clk on cs_rise while in INSTR, ADDR, or WR_DA/RD_DA with a partially shifted byte. Undefined: frame_err_o tied 0, detection logic absent.

## Test plan
- Single write: imode=01, admode=01, adsize=10, dmode=01, fmode=00, instr 0x02, addr 0x123456, data 0xA5,0x3C -> cmd_valid once, instr 0x02, addr 0x00123456; wr_dat_valid twice with 0xA5 then 0x3C; spi_d_oe stays 0.
- Quad read: imode=01, admode=11, adsize=11, dmode=11, fmode=01, instr 0xEB, addr 0x89ABCDEF, source 0x11,0x22,0x33 -> host captures 0x11,0x22,0x33; rd_dat_rdreq one pulse per started byte; oe 4'hf only in data phase.
- Dual, no instruction: imode=00, admode=10, adsize=00, addr 0x5A, dmode=10, fmode=00, data 0xC3 -> cmd_instr 0x00, cmd_addr 0x0000005A, wr_dat 0xC3.
- Instruction only: imode=01, admode=00, dmode=00, instr 0x06 -> cmd_valid with addr 0, no data pulses, busy drops after CS_n high.
- Abort after 12 address bits -> frame_err pulse (macro on) / none (off); no cmd_valid; next frame decodes correctly.
- rst_i asserted mid RD_DA -> next cycle spi_d_oe 0, spi_d_o 4'hf, busy 0; remaining SCLK edges ignored until CS_n high-then-low.
